bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: one-hot grant, revoke-on-idle timeout,
// one dead turnaround cycle between owners, and a protocol-error flag for rogue M_UTIL.
module bus_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int GRANT_TIMEOUT = 16,
    localparam int IDW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NUM_MASTERS-1:0] M_REQ,
    input  logic [NUM_MASTERS-1:0] M_UTIL,
    output logic [NUM_MASTERS-1:0] M_GRANT,
    output logic [IDW-1:0]         GRANT_ID,
    output logic                   BUS_BSY,
    output logic                   TIMEOUT,
    output logic                   PROT_ERR
);

    localparam int TW = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDW-1:0]         r_id;
    logic [IDW-1:0]         r_last;
    logic [TW-1:0]          r_timer;
    logic                   r_bsy;
    logic                   r_tout;
    logic                   r_prot;

    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IDW-1:0]         w_id_nxt;
    logic [IDW-1:0]         w_last_nxt;
    logic [TW-1:0]          w_timer_nxt;
    logic                   w_tout_nxt;
    logic                   w_prot_nxt;
    logic [IDW-1:0]         w_pick;
    logic                   w_found;
    logic                   w_own_util;
    logic                   w_own_req;

    // First requester after the previous owner, wrapping; the previous owner is searched last.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!w_found && M_REQ[(int'(r_last) + k) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(r_last) + k) % NUM_MASTERS);
            end
        end
    end

    assign w_own_util = M_UTIL[r_id];
    assign w_own_req  = M_REQ[r_id];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last;
        w_timer_nxt = r_timer;
        w_tout_nxt  = 1'b0;
        w_prot_nxt  = |(M_UTIL & ~r_grant);
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = NUM_MASTERS'(1) << w_pick;
                    w_id_nxt    = w_pick;
                    w_last_nxt  = w_pick;
                    w_timer_nxt = '0;
                end
            end
            GRANTED: begin
                if (w_own_util) begin
                    w_state_nxt = BUSY;
                end else if (!w_own_req) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                end else if (r_timer == TW'(GRANT_TIMEOUT - 1)) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            BUSY: begin
                if (!w_own_util) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_id    <= '0;
            r_last  <= IDW'(NUM_MASTERS - 1);
            r_timer <= '0;
            r_bsy   <= 1'b0;
            r_tout  <= 1'b0;
            r_prot  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_timer <= w_timer_nxt;
            r_bsy   <= |w_grant_nxt;
            r_tout  <= w_tout_nxt;
            r_prot  <= w_prot_nxt;
        end
    end

    assign M_GRANT  = r_grant;
    assign GRANT_ID = r_id;
    assign BUS_BSY  = r_bsy;
    assign TIMEOUT  = r_tout;
    assign PROT_ERR = r_prot;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, every cycle checked
// against an owner/cooldown model of the arbitration rules.
module tb_bus_arbiter;

    localparam int N    = 2;
    localparam int TOUT = 16;
    localparam int IDW  = 1;

    logic           CLK;
    logic           RSTN;
    logic [N-1:0]   M_REQ;
    logic [N-1:0]   M_UTIL;
    logic [N-1:0]   M_GRANT;
    logic [IDW-1:0] GRANT_ID;
    logic           BUS_BSY;
    logic           TIMEOUT;
    logic           PROT_ERR;

    bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(TOUT)) dut (
        .CLK(CLK), .RSTN(RSTN), .M_REQ(M_REQ), .M_UTIL(M_UTIL),
        .M_GRANT(M_GRANT), .GRANT_ID(GRANT_ID), .BUS_BSY(BUS_BSY),
        .TIMEOUT(TIMEOUT), .PROT_ERR(PROT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus, whether the owner has started, how long it has waited,
    // and how many turnaround cycles remain before arbitration may run again.
    int m_owner, m_last, m_waited, m_cool;
    bit m_started, m_tout, m_prot;

    int g0_cnt, g1_cnt, prot_cnt, tout_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        if (m_owner < 0) return '0;
        return N'(1) << m_owner;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_waited = 0; m_cool = 0;
        m_started = 0; m_tout = 0; m_prot = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] util);
        logic [N-1:0] g;
        g = exp_grant();
        m_prot = |(util & ~g);
        m_tout = 0;
        if (m_owner < 0) begin
            if (m_cool > 0) m_cool--;
            else if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner; m_started = 0; m_waited = 1;
            end
        end else if (!m_started) begin
            if (util[m_owner]) m_started = 1;
            else if (!req[m_owner]) begin m_owner = -1; m_cool = 1; end
            else if (m_waited == TOUT) begin m_owner = -1; m_cool = 1; m_tout = 1; end
            else m_waited++;
        end else if (!util[m_owner]) begin
            m_owner = -1; m_cool = 1;
        end
    endtask

    task automatic compare_all();
        check("grant", int'(M_GRANT), int'(exp_grant()));
        check("bus_bsy", int'(BUS_BSY), (m_owner >= 0) ? 1 : 0);
        check("timeout", int'(TIMEOUT), int'(m_tout));
        check("prot_err", int'(PROT_ERR), int'(m_prot));
        check("onehot0", int'($onehot0(M_GRANT)), 1);
        if (m_owner >= 0) check("grant_id", int'(GRANT_ID), m_owner);
        g0_cnt   += int'(M_GRANT[0]);
        g1_cnt   += int'(M_GRANT[1]);
        prot_cnt += int'(PROT_ERR);
        tout_cnt += int'(TIMEOUT);
    endtask

    // Called at a negedge: drive, let the edge happen, update model, compare.
    task automatic do_cycle(input logic [N-1:0] req, input logic [N-1:0] util);
        M_REQ  = req;
        M_UTIL = util;
        @(posedge CLK);
        model_step(req, util);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic wait_grant(input logic [N-1:0] req, output int cycles);
        cycles = 0;
        do begin
            do_cycle(req, '0);
            cycles++;
        end while (m_owner < 0 && cycles < 40);
        if (m_owner < 0) check("wait_grant_bound", cycles, -1);
    endtask

    task automatic clr_cnt();
        g0_cnt = 0; g1_cnt = 0; prot_cnt = 0; tout_cnt = 0;
    endtask

    initial begin
        int cyc;
        logic [N-1:0] r, u;
        model_reset();
        clr_cnt();
        RSTN = 1'b1; M_REQ = '0; M_UTIL = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_grant", int'(M_GRANT), 0);
        check("rst_id", int'(GRANT_ID), 0);
        check("rst_bsy", int'(BUS_BSY), 0);
        check("rst_tout", int'(TIMEOUT), 0);
        check("rst_prot", int'(PROT_ERR), 0);
        RSTN = 1'b0;

        // Single master, long transfer.
        wait_grant(2'b01, cyc);
        check("s1_latency", cyc, 1);
        check("s1_grant", int'(M_GRANT), 1);
        for (int i = 0; i < 30; i++) do_cycle(2'b01, 2'b01);
        do_cycle(2'b00, 2'b00);
        check("s1_drop", int'(M_GRANT), 0);
        check("s1_hold_cycles", g0_cnt, 31);
        do_cycle(2'b00, 2'b00);

        // Both requesting: alternate owners, two grant-low cycles between grants.
        for (int g = 0; g < 4; g++) begin
            wait_grant(2'b11, cyc);
            check("s2_owner", int'(M_GRANT), (g % 2 == 0) ? 2 : 1);
            if (g > 0) check("s2_gap", cyc, 2);
            for (int i = 0; i < 5; i++) do_cycle(2'b11, N'(1) << m_owner);
            do_cycle(2'b11, 2'b00);
        end

        // Master 1 withdraws before starting; it then loses priority to master 0.
        clr_cnt();
        wait_grant(2'b10, cyc);
        check("s5_grant", int'(M_GRANT), 2);
        do_cycle(2'b00, 2'b00);
        check("s5_drop", int'(M_GRANT), 0);
        check("s5_no_tout", tout_cnt, 0);
        wait_grant(2'b11, cyc);
        check("s5_next_owner", int'(M_GRANT), 1);
        do_cycle(2'b00, 2'b00);

        // Timeout: master 1 never asserts M_UTIL.
        clr_cnt();
        wait_grant(2'b10, cyc);
        for (int i = 0; i < 17; i++) do_cycle(2'b10, 2'b00);
        check("s3_grant_cycles", g1_cnt, 16);
        check("s3_tout_pulses", tout_cnt, 1);
        do_cycle(2'b00, 2'b00);
        do_cycle(2'b00, 2'b00);

        // Protocol error from a non-owner while master 0 is busy.
        clr_cnt();
        wait_grant(2'b01, cyc);
        do_cycle(2'b01, 2'b01);
        for (int i = 0; i < 3; i++) do_cycle(2'b01, 2'b11);
        for (int i = 0; i < 2; i++) do_cycle(2'b01, 2'b01);
        check("s4_prot_cycles", prot_cnt, 3);
        check("s4_g0_cycles", g0_cnt, 7);
        check("s4_g1_cycles", g1_cnt, 0);

        // Asynchronous reset mid-transfer.
        RSTN = 1'b1;
        #1;
        check("s6_async_grant", int'(M_GRANT), 0);
        check("s6_async_bsy", int'(BUS_BSY), 0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b0;
        wait_grant(2'b11, cyc);
        check("s6_first_owner", int'(M_GRANT), 1);
        do_cycle(2'b00, 2'b00);
        do_cycle(2'b00, 2'b00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = '0; u = '0;
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 9) < 6) r[j] = 1'b1;
                if ($urandom_range(0, 49) == 0) u[j] = 1'b1;
            end
            if (m_owner >= 0 && $urandom_range(0, 9) < 7) u[m_owner] = 1'b1;
            do_cycle(r, u);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
